relu_stream: RTL and testbench

- Streaming, parametrised activation unit for the LinearEmbedding datapath.
- Replaces the fixed 15x16 combinational ReLU.
- Consumes one row of LANES signed elements per beat under valid/ready and applies a per-tile selectable activation: ReLU, clipped ReLU, or leaky ReLU.
- Two-stage pipeline with full throughput and backpressure; flags the final row of each ROWS-row tile.

---
 rtl/relu_stream.sv | 236 +++++++++++++++++++++++
 tb/tb_relu_stream.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_stream.sv
// relu_stream: two-stage streaming activation unit.
// Each beat carries one row of LANES signed elements. The activation is chosen
// per tile: ReLU, clipped ReLU or leaky ReLU. The mode and clip ceiling are
// captured on the first row of each ROWS-row tile and travel with every beat.
// The final row of each tile is flagged on out_last.
// Optional build macro RELU_STATS_EN adds a per-tile zero-element counter
// (zero_cnt / zero_cnt_valid).

module relu_stream #(
   parameter int DATA_W      = 8,
   parameter int LANES       = 16,
   parameter int ROWS        = 15,
   parameter int LEAKY_SHIFT = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              mode,
   input  logic [DATA_W-1:0]       clip_val,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic                    out_last,
   output logic                    busy
`ifdef RELU_STATS_EN
   ,
   output logic [$clog2(ROWS*LANES+1)-1:0] zero_cnt,
   output logic                            zero_cnt_valid
`endif
);

   localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int ROW_W = LANES * DATA_W;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS - 1);
   localparam logic signed [DATA_W-1:0] ZERO_S = {DATA_W{1'b0}};

   // Per-lane activation. Leaky mode relies on >>> flooring toward -inf.
   // A non-positive clip ceiling forces every lane to zero.
   function automatic logic [DATA_W-1:0] act_fn(
      input logic signed [DATA_W-1:0] x,
      input logic [1:0]               m,
      input logic signed [DATA_W-1:0] c
   );
      logic signed [DATA_W-1:0] y;
      case (m)
         2'd1: begin
            if ((x <= ZERO_S) || (c <= ZERO_S)) begin
               y = ZERO_S;
            end else if (x > c) begin
               y = c;
            end else begin
               y = x;
            end
         end
         2'd2: begin
            if (x >= ZERO_S) begin
               y = x;
            end else begin
               y = x >>> LEAKY_SHIFT;
            end
         end
         default: begin
            if (x > ZERO_S) begin
               y = x;
            end else begin
               y = ZERO_S;
            end
         end
      endcase
      return y;
   endfunction

   // Tile state
   logic [CNT_W-1:0]  cnt_r;
   logic [1:0]        tile_mode_r;
   logic [DATA_W-1:0] tile_clip_r;

   // Stage 1: registered input beat plus its tile configuration
   logic              v1_r;
   logic [ROW_W-1:0]  data1_r;
   logic              last1_r;
   logic [1:0]        mode1_r;
   logic [DATA_W-1:0] clip1_r;

   // Stage 2: registered result
   logic              v2_r;
   logic [ROW_W-1:0]  data2_r;
   logic              last2_r;

   // Handshake and per-beat configuration
   logic              adv1_s;
   logic              adv2_s;
   logic              acc_s;
   logic [1:0]        beat_mode_s;
   logic [DATA_W-1:0] beat_clip_s;
   logic              beat_last_s;
   logic [ROW_W-1:0]  act_s;

   // Pipeline advance conditions; no skid buffer, so in_ready follows out_ready.
   always_comb begin
      adv2_s = !v2_r || out_ready;
      adv1_s = !v1_r || adv2_s;
      acc_s  = in_valid && adv1_s;
   end

   // The first row of a tile uses the live mode/clip inputs, later rows use the latched copy.
   always_comb begin
      if (cnt_r == CNT_ZERO) begin
         beat_mode_s = mode;
         beat_clip_s = clip_val;
      end else begin
         beat_mode_s = tile_mode_r;
         beat_clip_s = tile_clip_r;
      end
      beat_last_s = (cnt_r == CNT_LAST);
   end

   // Apply the activation lane by lane to the stage-1 row.
   always_comb begin
      act_s = {ROW_W{1'b0}};
      for (int k = 0; k < LANES; k++) begin
         act_s[k*DATA_W +: DATA_W] = act_fn(data1_r[k*DATA_W +: DATA_W], mode1_r, clip1_r);
      end
   end

   // Row counter and tile configuration latch, updated on every accepted beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r       <= CNT_ZERO;
         tile_mode_r <= 2'd0;
         tile_clip_r <= {DATA_W{1'b0}};
      end else if (acc_s) begin
         if (beat_last_s) begin
            cnt_r <= CNT_ZERO;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
         end
         if (cnt_r == CNT_ZERO) begin
            tile_mode_r <= mode;
            tile_clip_r <= clip_val;
         end
      end
   end

   // Stage 1 register: capture the accepted beat with its configuration and last flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_r    <= 1'b0;
         data1_r <= {ROW_W{1'b0}};
         last1_r <= 1'b0;
         mode1_r <= 2'd0;
         clip1_r <= {DATA_W{1'b0}};
      end else if (adv1_s) begin
         v1_r <= acc_s;
         if (acc_s) begin
            data1_r <= in_data;
            last1_r <= beat_last_s;
            mode1_r <= beat_mode_s;
            clip1_r <= beat_clip_s;
         end
      end
   end

   // Stage 2 register: hold the activated row steady while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         v2_r    <= 1'b0;
         data2_r <= {ROW_W{1'b0}};
         last2_r <= 1'b0;
      end else if (adv2_s) begin
         v2_r <= v1_r;
         if (v1_r) begin
            data2_r <= act_s;
            last2_r <= last1_r;
         end else begin
            last2_r <= 1'b0;
         end
      end
   end

   assign in_ready  = adv1_s;
   assign out_valid = v2_r;
   assign out_data  = data2_r;
   assign out_last  = last2_r;
   assign busy      = (cnt_r != CNT_ZERO) || v1_r || v2_r;

`ifdef RELU_STATS_EN
   localparam int ZW = $clog2(ROWS*LANES+1);
   localparam int PW = $clog2(LANES+1);

   logic [PW-1:0] beat_zeros_s;
   logic          hs_s;
   logic [ZW-1:0] zero_acc_r;
   logic [ZW-1:0] zero_cnt_r;
   logic          zero_cnt_valid_r;

   // Count zero lanes in the row currently presented on the output.
   always_comb begin
      beat_zeros_s = {PW{1'b0}};
      hs_s         = v2_r && out_ready;
      for (int k = 0; k < LANES; k++) begin
         if (data2_r[k*DATA_W +: DATA_W] == {DATA_W{1'b0}}) begin
            beat_zeros_s = beat_zeros_s + PW'(1'b1);
         end else begin
            beat_zeros_s = beat_zeros_s;
         end
      end
   end

   // Accumulate per-tile zeros on output handshakes; publish and clear on the last row.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_acc_r       <= {ZW{1'b0}};
         zero_cnt_r       <= {ZW{1'b0}};
         zero_cnt_valid_r <= 1'b0;
      end else begin
         zero_cnt_valid_r <= hs_s && last2_r;
         if (hs_s) begin
            if (last2_r) begin
               zero_cnt_r <= zero_acc_r + ZW'(beat_zeros_s);
               zero_acc_r <= {ZW{1'b0}};
            end else begin
               zero_acc_r <= zero_acc_r + ZW'(beat_zeros_s);
            end
         end
      end
   end

   assign zero_cnt       = zero_cnt_r;
   assign zero_cnt_valid = zero_cnt_valid_r;
`endif

endmodule

// File: tb/tb_relu_stream.sv
// Directed testbench for relu_stream: table of hand-computed single-row
// vectors applied as full tiles, plus sequences for latency, mid-tile mode
// change, backpressure/stall and mid-tile reset. A scoreboard queue holds
// expected rows in acceptance order and is checked on every output handshake.

module tb_relu_stream;

   localparam int DW = 8;
   localparam int LN = 16;
   localparam int RW = 15;
   localparam int LS = 3;
   localparam int BW = DW * LN;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    mode;
   logic [DW-1:0] clip_val;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] out_data;
   logic          out_last;
   logic          busy;
`ifdef RELU_STATS_EN
   logic [$clog2(RW*LN+1)-1:0] zero_cnt;
   logic                       zero_cnt_valid;
   int                         pulses = 0;
   int                         last_zc = 0;
`endif

   int checks   = 0;
   int failures = 0;
   int bp       = 0;
   int tb_row   = 0;

   typedef struct {
      logic [BW-1:0] d;
      logic          l;
   } exp_t;
   exp_t q[$];
   exp_t mon_e;

   typedef struct {
      logic [1:0]      m;
      logic [7:0]      c;
      logic [4:0][7:0] x;
      logic [4:0][7:0] y;
   } vec_t;
   vec_t tbl[7];

   logic          stall_prev = 1'b0;
   logic [BW-1:0] held_d;
   logic          held_l;

   relu_stream #(
      .DATA_W(DW), .LANES(LN), .ROWS(RW), .LEAKY_SHIFT(LS)
   ) dut (
      .clk(clk), .rst(rst), .mode(mode), .clip_val(clip_val),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy)
`ifdef RELU_STATS_EN
      , .zero_cnt(zero_cnt), .zero_cnt_valid(zero_cnt_valid)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string nm, input logic [BW-1:0] act, input logic [BW-1:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic logic [4:0][7:0] p5(input int a, input int b, input int c, input int d, input int e);
      logic [4:0][7:0] r;
      r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d); r[4] = 8'(e);
      return r;
   endfunction

   function automatic logic [BW-1:0] expand(input logic [4:0][7:0] v);
      logic [BW-1:0] r;
      for (int k = 0; k < LN; k++) r[k*DW +: DW] = v[k % 5];
      return r;
   endfunction

   // Reference activation in plain integer arithmetic.
   function automatic int act_model(input int x, input int m, input int c);
      if (m == 1) begin
         if (x <= 0 || c <= 0) return 0;
         return (x > c) ? c : x;
      end else if (m == 2) begin
         if (x >= 0) return x;
         return -((-x + (1 << LS) - 1) >> LS);
      end
      return (x > 0) ? x : 0;
   endfunction

   function automatic logic [BW-1:0] mk_row(input int r);
      logic [BW-1:0] d;
      for (int k = 0; k < LN; k++) d[k*DW +: DW] = 8'(((r * 37 + k * 23) % 256) - 128);
      return d;
   endfunction

   function automatic logic [BW-1:0] model_row(input logic [BW-1:0] d, input int m, input int c);
      logic [BW-1:0] r;
      for (int k = 0; k < LN; k++) begin
         r[k*DW +: DW] = 8'(act_model(int'($signed(d[k*DW +: DW])), m, c));
      end
      return r;
   endfunction

   task automatic set_vec(input int i, input logic [1:0] m, input int c,
                          input logic [4:0][7:0] x, input logic [4:0][7:0] y);
      tbl[i].m = m; tbl[i].c = 8'(c); tbl[i].x = x; tbl[i].y = y;
   endtask

   // Present one beat; call right after a posedge (+#1). Records the expected row on acceptance.
   task automatic send(input logic [BW-1:0] d, input logic [1:0] m, input logic [7:0] c, input logic [BW-1:0] e);
      bit   ok = 1'b0;
      exp_t x;
      in_data = d; mode = m; clip_val = c; in_valid = 1'b1;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            x.d = e;
            x.l = (tb_row == RW - 1);
            q.push_back(x);
            tb_row = (tb_row + 1) % RW;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk(1'b0, "accept_timeout", BW'(in_ready), BW'(1));
      #1 in_valid = 1'b0;
   endtask

   // Wait for the scoreboard to empty; returns aligned just after a posedge.
   task automatic drain();
      bit ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (q.size() == 0 && !out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk(ok, "drain", BW'(q.size()), BW'(0));
      if (ok && tb_row == 0) chk(!busy, "idle_busy", BW'(busy), BW'(0));
      @(posedge clk);
      #1;
   endtask

   // Downstream ready pattern: 0 always ready, 1 random, 2 stalled.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (bp)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Output monitor: scoreboard compare on handshakes and hold check during stalls.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk(out_valid === 1'b1, "hold_valid", BW'(out_valid), BW'(1));
            chk(out_data === held_d, "hold_data", out_data, held_d);
            chk(out_last === held_l, "hold_last", BW'(out_last), BW'(held_l));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk(1'b0, "extra_beat", out_data, '0);
            end else begin
               mon_e = q.pop_front();
               chk(out_data === mon_e.d, "data", out_data, mon_e.d);
               chk(out_last === mon_e.l, "last", BW'(out_last), BW'(mon_e.l));
            end
         end
         stall_prev = out_valid && !out_ready;
         held_d     = out_data;
         held_l     = out_last;
`ifdef RELU_STATS_EN
         if (zero_cnt_valid) begin
            pulses++;
            last_zc = int'(zero_cnt);
         end
`endif
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; mode = 2'd0; clip_val = 8'd0; in_data = '0;

      set_vec(0, 2'd0,   0, p5(-128, -1, 0, 1, 127), p5(0, 0, 0, 1, 127));
      set_vec(1, 2'd1,   6, p5(-5, 3, 6, 7, 100),    p5(0, 3, 6, 6, 6));
      set_vec(2, 2'd1,  -4, p5(-5, 3, 6, 7, 100),    p5(0, 0, 0, 0, 0));
      set_vec(3, 2'd2,   0, p5(-1, -8, -9, -128, 5), p5(-1, -1, -2, -16, 5));
      set_vec(4, 2'd3,   0, p5(-128, -1, 0, 1, 127), p5(0, 0, 0, 1, 127));
      set_vec(5, 2'd1, 127, p5(-128, -1, 0, 1, 127), p5(0, 0, 0, 1, 127));
      set_vec(6, 2'd2,   0, p5(0, 1, -2, -127, 127), p5(0, 1, -1, -16, 127));

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk(!out_valid, "rst_out_valid", BW'(out_valid), BW'(0));
      chk(out_data == '0, "rst_out_data", out_data, '0);
      chk(!out_last, "rst_out_last", BW'(out_last), BW'(0));
      chk(!busy, "rst_busy", BW'(busy), BW'(0));
      chk(in_ready, "rst_in_ready", BW'(in_ready), BW'(1));
      @(posedge clk);
      #1;

      // Two-cycle latency on the first beat
      send(expand(tbl[0].x), tbl[0].m, tbl[0].c, expand(tbl[0].y));
      @(negedge clk);
      chk(!out_valid, "latency_c1", BW'(out_valid), BW'(0));
      @(negedge clk);
      chk(out_valid && out_data == expand(tbl[0].y), "latency_c2", out_data, expand(tbl[0].y));
      @(posedge clk);
      #1;
      for (int r = 1; r < RW; r++) send(expand(tbl[0].x), tbl[0].m, tbl[0].c, expand(tbl[0].y));

      // Table vectors, each applied as a full tile
      for (int i = 1; i < 7; i++) begin
         for (int r = 0; r < RW; r++) send(expand(tbl[i].x), tbl[i].m, tbl[i].c, expand(tbl[i].y));
      end
      drain();

      // Mode change mid-tile is ignored; next tile in leaky mode overlaps the drain
      bp = 1;
      for (int r = 0; r < RW; r++) send(mk_row(r), (r < 7) ? 2'd0 : 2'd2, 8'd0, model_row(mk_row(r), 0, 0));
      for (int r = 0; r < RW; r++) send(mk_row(r + 20), 2'd2, 8'd0, model_row(mk_row(r + 20), 2, 0));
      drain();

      // Backpressure with a 10-cycle full stall
      for (int r = 0; r < 5; r++) send(mk_row(40 + r), 2'd1, 8'd6, model_row(mk_row(40 + r), 1, 6));
      drain();
      bp = 2;
      for (int r = 5; r < 7; r++) send(mk_row(40 + r), 2'd1, 8'd6, model_row(mk_row(40 + r), 1, 6));
      @(negedge clk);
      chk(!in_ready, "full_in_ready", BW'(in_ready), BW'(0));
      chk(busy, "full_busy", BW'(busy), BW'(1));
      repeat (10) @(negedge clk);
      @(posedge clk);
      #1 bp = 1;
      for (int r = 7; r < RW; r++) send(mk_row(40 + r), 2'd1, 8'd6, model_row(mk_row(40 + r), 1, 6));
      drain();

      // Reset at row 5 with both stages full
      bp = 0;
      for (int r = 0; r < 5; r++) send(mk_row(60 + r), 2'd0, 8'd0, model_row(mk_row(60 + r), 0, 0));
      drain();
      bp = 2;
      for (int r = 5; r < 7; r++) send(mk_row(60 + r), 2'd0, 8'd0, model_row(mk_row(60 + r), 0, 0));
      @(negedge clk);
      chk(!in_ready, "prerst_in_ready", BW'(in_ready), BW'(0));
      @(posedge clk);
      #1 rst = 1'b1;
      q.delete();
      tb_row = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk(!out_valid, "midrst_out_valid", BW'(out_valid), BW'(0));
      chk(!busy, "midrst_busy", BW'(busy), BW'(0));
      chk(in_ready, "midrst_in_ready", BW'(in_ready), BW'(1));
      @(posedge clk);
      #1 bp = 0;
      for (int r = 0; r < RW; r++) send(mk_row(80 + r), 2'd2, 8'd0, model_row(mk_row(80 + r), 2, 0));
      drain();

`ifdef RELU_STATS_EN
      pulses = 0;
      for (int r = 0; r < RW; r++) send(expand(p5(-3, -7, -1, -128, -50)), 2'd0, 8'd0, '0);
      drain();
      repeat (3) @(negedge clk);
      chk(pulses == 1, "zc_pulses", BW'(pulses), BW'(1));
      chk(last_zc == RW * LN, "zc_value", BW'(last_zc), BW'(RW * LN));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
